// File: rtl/q_policy_reader_if.sv
// q_policy_reader_if
// Groups the request, response and Q-table read-port signals of the greedy
// policy reader into a single bundle.
//   slave  : the reader itself (accepts requests, drives the table port)
//   master : the surrounding system (issues requests, serves table reads)
// Signal names keep their i_/o_ prefixes as seen from the reader.
interface q_policy_reader_if #(
  parameter int STATE_WIDTH  = 6,
  parameter int ACTION_WIDTH = 2,
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 8
);
  logic                    i_req_valid;
  logic                    o_req_ready;
  logic [STATE_WIDTH-1:0]  i_req_state;
  logic                    o_rsp_valid;
  logic                    i_rsp_ready;
  logic [ACTION_WIDTH-1:0] o_rsp_action;
  logic [DATA_WIDTH-1:0]   o_rsp_qval;
  logic                    o_q_rd;
  logic [ADDR_WIDTH-1:0]   o_q_addr;
  logic [DATA_WIDTH-1:0]   i_q_data;
  logic                    i_q_busy;

  modport slave (
    input  i_req_valid, i_req_state, i_rsp_ready, i_q_data, i_q_busy,
    output o_req_ready, o_rsp_valid, o_rsp_action, o_rsp_qval, o_q_rd, o_q_addr
  );

  modport master (
    output i_req_valid, i_req_state, i_rsp_ready, i_q_data, i_q_busy,
    input  o_req_ready, o_rsp_valid, o_rsp_action, o_rsp_qval, o_q_rd, o_q_addr
  );
endinterface

// File: rtl/q_policy_reader.sv
// q_policy_reader
// Greedy-policy readout: for a requested state, reads all Q(s,a) entries from
// the Q-table read port and returns the arg-max action and its Q value.
// Yields the table port whenever the writer holds i_q_busy.
// Ports:
//   i_clk  : clock, rising edge
//   i_rst  : asynchronous active-high reset
//   bus    : q_policy_reader_if.slave (request, response, table read port)
//
// state | meaning
// IDLE  | ready for a request
// READ  | issuing one table read per action, stalling on i_q_busy
// DRAIN | capturing the data of the last read
// RESP  | holding the result until the consumer accepts it
module q_policy_reader #(
  parameter int STATE_WIDTH  = 6,
  parameter int ACTION_WIDTH = 2,
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 8
) (
  input logic              i_clk,
  input logic              i_rst,
  q_policy_reader_if.slave bus
);
  localparam logic [ACTION_WIDTH-1:0] LAST_ACT = {ACTION_WIDTH{1'b1}};

  typedef enum logic [1:0] {IDLE, READ, DRAIN, RESP} state_e;

  state_e                  state_q, state_d;
  logic [STATE_WIDTH-1:0]  st_q;
  logic [ACTION_WIDTH-1:0] cnt_q;
  logic [ACTION_WIDTH-1:0] tag_q;
  logic                    rd_pending_q;
  logic                    first_q;
  logic [DATA_WIDTH-1:0]   best_q;
  logic [ACTION_WIDTH-1:0] best_act_q;

  logic req_ready, rsp_valid, q_rd;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.i_req_valid) state_d = READ;
      READ:    if (q_rd && cnt_q == LAST_ACT) state_d = DRAIN;
      DRAIN:   state_d = RESP;
      RESP:    if (bus.i_rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    q_rd      = 1'b0;
    case (state_q)
      IDLE:    req_ready = 1'b1;
      READ:    q_rd      = !bus.i_q_busy;
      RESP:    rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath: request latch, action counter and running arg-max.
  // tag_q remembers which action the in-flight read belongs to, since cnt_q
  // has already moved on by the time its data returns.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      st_q         <= '0;
      cnt_q        <= '0;
      tag_q        <= '0;
      rd_pending_q <= 1'b0;
      first_q      <= 1'b0;
      best_q       <= '0;
      best_act_q   <= '0;
    end else begin
      rd_pending_q <= q_rd;
      tag_q        <= cnt_q;
      if (state_q == IDLE && bus.i_req_valid) begin
        st_q    <= bus.i_req_state;
        cnt_q   <= '0;
        first_q <= 1'b1;
      end else if (q_rd) begin
        cnt_q <= cnt_q + 1'b1;
      end
      // Strictly-greater replace keeps the lowest action index on ties.
      if (rd_pending_q) begin
        first_q <= 1'b0;
        if (first_q || bus.i_q_data > best_q) begin
          best_q     <= bus.i_q_data;
          best_act_q <= tag_q;
        end
      end
    end
  end

  assign bus.o_req_ready  = req_ready;
  assign bus.o_rsp_valid  = rsp_valid;
  assign bus.o_q_rd       = q_rd;
  assign bus.o_q_addr     = ADDR_WIDTH'({st_q, cnt_q});
  assign bus.o_rsp_action = best_act_q;
  assign bus.o_rsp_qval   = best_q;
endmodule

// File: tb/tb_q_policy_reader.sv
module tb_q_policy_reader;
  localparam int SW = 6, AW = 2, DW = 8, ADW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  q_policy_reader_if #(.STATE_WIDTH(SW), .ACTION_WIDTH(AW), .DATA_WIDTH(DW),
                       .ADDR_WIDTH(ADW)) bus ();

  q_policy_reader #(.STATE_WIDTH(SW), .ACTION_WIDTH(AW), .DATA_WIDTH(DW),
                    .ADDR_WIDTH(ADW)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));

  // Q-table BRAM model: data returns the cycle after a sampled read.
  logic [7:0] mem [256];
  logic [7:0] addrq [$];
  always @(posedge clk) begin
    if (bus.o_q_rd) begin
      bus.i_q_data <= mem[bus.o_q_addr];
      addrq.push_back(bus.o_q_addr);
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: first index holding the maximum of the four entries.
  task automatic ref_best(input int s, output int act, output int qv);
    act = 0;
    qv  = mem[s*4];
    for (int a = 1; a < 4; a++)
      if (int'(mem[s*4+a]) > qv) begin
        act = a;
        qv  = mem[s*4+a];
      end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, bus.o_req_ready, 1);
    chk({tag, "_rsp_valid"}, bus.o_rsp_valid, 0);
    chk({tag, "_action"}, bus.o_rsp_action, 0);
    chk({tag, "_qval"}, bus.o_rsp_qval, 0);
    chk({tag, "_q_rd"}, bus.o_q_rd, 0);
    chk({tag, "_q_addr"}, bus.o_q_addr, 0);
  endtask

  // One request; busy is held for bl cycles starting at cycle bs after
  // acceptance (bs in 1..4 lands inside the read window); the consumer
  // withholds ready for `stall` cycles.
  task automatic run_req(input int s, input int bs, input int bl, input int stall);
    int ea, eq, lat, exp_lat;
    bit got;
    ref_best(s, ea, eq);
    exp_lat = 5 + bl;
    addrq.delete();
    @(negedge clk);
    chk("req_ready_idle", bus.o_req_ready, 1);
    bus.i_req_valid = 1'b1;
    bus.i_req_state = SW'(s);
    @(posedge clk);
    #1 bus.i_req_valid = 1'b0;
    got = 0;
    lat = 0;
    for (int c = 1; c <= 60 && !got; c++) begin
      bus.i_q_busy = (c >= bs) && (c < bs + bl);
      @(negedge clk);
      if (c == 1) chk("req_ready_low", bus.o_req_ready, 0);
      if (bus.i_q_busy) begin
        chk("busy_no_rd", bus.o_q_rd, 0);
        chk("busy_addr_hold", bus.o_q_addr, s*4 + addrq.size());
      end
      if (bus.o_rsp_valid) begin
        got = 1;
        lat = c - 1;
      end else begin
        @(posedge clk);
        #1;
      end
    end
    bus.i_q_busy = 1'b0;
    if (!got) begin
      chk("rsp_timeout", 0, 1);
      return;
    end
    chk("latency", lat, exp_lat);
    chk("action", bus.o_rsp_action, ea);
    chk("qval", bus.o_rsp_qval, eq);
    chk("num_reads", addrq.size(), 4);
    for (int a = 0; a < 4 && a < addrq.size(); a++)
      chk("read_addr", addrq[a], s*4 + a);
    for (int k = 0; k < stall; k++) begin
      bus.i_req_valid = 1'b1;
      bus.i_req_state = SW'(s ^ 1);
      @(posedge clk);
      @(negedge clk);
      chk("stall_valid", bus.o_rsp_valid, 1);
      chk("stall_action", bus.o_rsp_action, ea);
      chk("stall_qval", bus.o_rsp_qval, eq);
      chk("stall_req_ready", bus.o_req_ready, 0);
      chk("stall_no_rd", bus.o_q_rd, 0);
    end
    bus.i_req_valid = 1'b0;
    bus.i_rsp_ready = 1'b1;
    @(posedge clk);
    #1 bus.i_rsp_ready = 1'b0;
    @(negedge clk);
    chk("rsp_done_valid", bus.o_rsp_valid, 0);
    chk("rsp_done_ready", bus.o_req_ready, 1);
  endtask

  initial begin
    rst             = 1'b1;
    bus.i_req_valid = 1'b0;
    bus.i_req_state = '0;
    bus.i_rsp_ready = 1'b0;
    bus.i_q_busy    = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(0, 255));
    mem[20] = 8'h10; mem[21] = 8'h30; mem[22] = 8'h20; mem[23] = 8'h05;
    for (int a = 0; a < 4; a++) mem[252+a] = 8'h40;
    mem[0] = 8'h00; mem[1] = 8'h00; mem[2] = 8'h00; mem[3] = 8'hFF;
    for (int a = 0; a < 4; a++) mem[40+a] = 8'h00;

    #12;
    check_reset_outputs("por");
    @(negedge clk);
    rst = 1'b0;

    run_req(5, 0, 0, 0);
    run_req(63, 0, 0, 0);
    run_req(0, 0, 0, 0);
    run_req(10, 0, 0, 0);
    run_req(5, 3, 2, 0);
    run_req(5, 0, 0, 3);

    // Abort during READ of state 9.
    @(negedge clk);
    bus.i_req_valid = 1'b1;
    bus.i_req_state = SW'(9);
    @(posedge clk);
    #1 bus.i_req_valid = 1'b0;
    @(posedge clk);
    #3 rst = 1'b1;
    #1 check_reset_outputs("abort");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("abort_rst_rd", bus.o_q_rd, 0);
      chk("abort_rst_valid", bus.o_rsp_valid, 0);
    end
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("abort_post_rd", bus.o_q_rd, 0);
      chk("abort_post_valid", bus.o_rsp_valid, 0);
      chk("abort_post_ready", bus.o_req_ready, 1);
    end
    run_req(5, 0, 0, 0);

    // Randomized requests; some states get a narrow value range to force ties.
    for (int t = 0; t < 25; t++) begin
      int s;
      bit narrow;
      s = int'($urandom_range(0, 63));
      narrow = ($urandom_range(0, 2) == 0);
      for (int a = 0; a < 4; a++)
        mem[s*4+a] = narrow ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
      run_req(s, int'($urandom_range(1, 4)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
